// File: rtl/fir_interp_iq.sv
// Interpolate-by-2 symmetric FIR for complex I/Q samples. Each accepted input
// yields a phase-0 and a phase-1 output, computed with one serial MAC per rail.
module fir_interp_iq #(
  parameter int WIDTH = 24,
  parameter int COEFF = 18,
  parameter int NTAPS = 33
) (
  input  logic                                 adc_clk,
  input  logic                                 reset,
  input  logic                                 in_strobe,
  input  logic signed [WIDTH-1:0]              in_data_i,
  input  logic signed [WIDTH-1:0]              in_data_q,
  output logic                                 out_strobe,
  output logic signed [WIDTH-1:0]              out_data_i,
  output logic signed [WIDTH-1:0]              out_data_q,
  output logic                                 busy,
  output logic                                 overrun,
  input  logic                                 coef_wr,
  input  logic [$clog2((NTAPS+1)/2)-1:0]       coef_addr,
  input  logic signed [COEFF-1:0]              coef_data
);

  localparam int NH   = (NTAPS - 1) / 2;
  localparam int AW   = $clog2(NH + 1);
  localparam int KW   = $clog2(NTAPS) + 1;
  localparam int PW   = WIDTH + COEFF;
  localparam int ACCW = WIDTH + COEFF + $clog2(NTAPS);
  localparam int SH   = COEFF - 2;

  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_MAC0,
    S_OUT0,
    S_MAC1,
    S_OUT1
  } state_t;

  state_t state;
  state_t state_next;

  logic signed [WIDTH-1:0] buf_i [0:NH];
  logic signed [WIDTH-1:0] buf_q [0:NH];
  logic signed [COEFF-1:0] taps  [0:NH];

  logic [AW-1:0]           cnt;
  logic signed [ACCW-1:0]  acc_i;
  logic signed [ACCW-1:0]  acc_q;

  logic [KW-1:0]           k;
  logic [AW-1:0]           tap_idx;
  logic signed [COEFF-1:0] coef;
  logic signed [WIDTH-1:0] x_i;
  logic signed [WIDTH-1:0] x_q;
  logic signed [PW-1:0]    prod_i;
  logic signed [PW-1:0]    prod_q;
  logic                    mac_last;

  // Shift right by COEFF-2 (coefficient scale plus the x2 zero-stuff gain),
  // then clamp to the output range. Truncation toward -inf, no rounding.
  function automatic logic signed [WIDTH-1:0] saturate(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] s;
    s = a >>> SH;
    if (s > SAT_MAX) begin
      saturate = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (s < SAT_MIN) begin
      saturate = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      saturate = s[WIDTH-1:0];
    end
  endfunction

  // Full-filter tap k = 2*cnt + phase, folded onto the unique half by symmetry.
  always_comb begin
    k       = (KW'(cnt) << 1) | KW'(state == S_MAC1);
    tap_idx = '0;
    if (k <= KW'(NH)) begin
      tap_idx = AW'(k);
    end else begin
      tap_idx = AW'(KW'(NTAPS - 1) - k);
    end
    coef   = taps[tap_idx];
    x_i    = buf_i[cnt];
    x_q    = buf_q[cnt];
    prod_i = PW'(x_i) * PW'(coef);
    prod_q = PW'(x_q) * PW'(coef);
  end

  always_comb begin
    mac_last = ((state == S_MAC0) && (cnt == AW'(NH))) ||
               ((state == S_MAC1) && (cnt == AW'(NH - 1)));
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (in_strobe) state_next = S_LATCH;
      S_LATCH: state_next = S_MAC0;
      S_MAC0:  if (mac_last) state_next = S_OUT0;
      S_OUT0:  state_next = S_MAC1;
      S_MAC1:  if (mac_last) state_next = S_OUT1;
      S_OUT1:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      acc_i      <= '0;
      acc_q      <= '0;
      out_strobe <= 1'b0;
      out_data_i <= '0;
      out_data_q <= '0;
      overrun    <= 1'b0;
      for (int j = 0; j <= NH; j++) begin
        buf_i[j] <= '0;
        buf_q[j] <= '0;
        taps[j]  <= '0;
      end
      taps[NH]   <= COEFF'(2 ** SH);
    end else begin
      state      <= state_next;
      out_strobe <= 1'b0;

      if (coef_wr && (coef_addr <= AW'(NH))) begin
        taps[coef_addr] <= coef_data;
      end

      // A strobe outside IDLE is dropped; the running computation continues.
      if (in_strobe) begin
        if (state == S_IDLE) begin
          buf_i[0] <= in_data_i;
          buf_q[0] <= in_data_q;
          for (int j = 1; j <= NH; j++) begin
            buf_i[j] <= buf_i[j-1];
            buf_q[j] <= buf_q[j-1];
          end
        end else begin
          overrun <= 1'b1;
        end
      end

      case (state)
        S_LATCH: begin
          acc_i <= '0;
          acc_q <= '0;
          cnt   <= '0;
        end
        S_MAC0, S_MAC1: begin
          acc_i <= acc_i + ACCW'(prod_i);
          acc_q <= acc_q + ACCW'(prod_q);
          cnt   <= mac_last ? '0 : cnt + 1'b1;
        end
        S_OUT0: begin
          out_data_i <= saturate(acc_i);
          out_data_q <= saturate(acc_q);
          out_strobe <= 1'b1;
          acc_i      <= '0;
          acc_q      <= '0;
          cnt        <= '0;
        end
        S_OUT1: begin
          out_data_i <= saturate(acc_i);
          out_data_q <= saturate(acc_q);
          out_strobe <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_interp_iq.sv
// Testbench for fir_interp_iq: randomized and directed samples scored against
// a direct evaluation of the interpolating convolution sum.
module tb_fir_interp_iq;

  localparam int WIDTH  = 24;
  localparam int COEFF  = 18;
  localparam int NTAPS  = 33;
  localparam int NH     = (NTAPS - 1) / 2;
  localparam int AW     = $clog2(NH + 1);
  localparam int EW     = 32 + 2 * WIDTH;
  localparam int LAT_P0 = NH + 4;
  localparam int LAT_P1 = 2 * NH + 5;

  logic             adc_clk;
  logic             reset;
  logic             in_strobe;
  logic [WIDTH-1:0] in_data_i;
  logic [WIDTH-1:0] in_data_q;
  logic             out_strobe;
  logic [WIDTH-1:0] out_data_i;
  logic [WIDTH-1:0] out_data_q;
  logic             busy;
  logic             overrun;
  logic             coef_wr;
  logic [AW-1:0]    coef_addr;
  logic [COEFF-1:0] coef_data;

  fir_interp_iq #(.WIDTH(WIDTH), .COEFF(COEFF), .NTAPS(NTAPS)) dut (
    .adc_clk    (adc_clk),
    .reset      (reset),
    .in_strobe  (in_strobe),
    .in_data_i  (in_data_i),
    .in_data_q  (in_data_q),
    .out_strobe (out_strobe),
    .out_data_i (out_data_i),
    .out_data_q (out_data_q),
    .busy       (busy),
    .overrun    (overrun),
    .coef_wr    (coef_wr),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data)
  );

  // ---------------- clock / reset ----------------
  initial adc_clk = 1'b0;
  always #5 adc_clk = ~adc_clk;

  int cyc = 0;
  always @(posedge adc_clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int checks     = 0;
  int failures   = 0;
  int strobe_cnt = 0;
  bit prev_strobe = 1'b0;

  // Reference model: full coefficient knowledge plus complete input history.
  int tm[0:NH];
  int hist_i[$];
  int hist_q[$];

  function automatic void model_reset();
    for (int j = 0; j <= NH; j++) tm[j] = 0;
    tm[NH] = 1 << (COEFF - 2);
    hist_i.delete();
    hist_q.delete();
  endfunction

  function automatic int h_full(input int kk);
    if (kk <= NH) return tm[kk];
    return tm[NTAPS - 1 - kk];
  endfunction

  // y[2n+p] = sum_j h[2j+p] * x[n-j], samples before the first are zero.
  function automatic logic [WIDTH-1:0] model_y(input int p, input bit rail_q);
    longint s;
    longint smax;
    longint smin;
    int n;
    int xv;
    s    = 0;
    smax = (longint'(1) << (WIDTH - 1)) - 1;
    smin = -(longint'(1) << (WIDTH - 1));
    n    = hist_i.size() - 1;
    for (int j = 0; 2 * j + p < NTAPS; j++) begin
      xv = 0;
      if (n - j >= 0) xv = rail_q ? hist_q[n - j] : hist_i[n - j];
      s += longint'(h_full(2 * j + p)) * longint'(xv);
    end
    s = s >>> (COEFF - 2);
    if (s > smax) s = smax;
    if (s < smin) s = smin;
    return WIDTH'(s);
  endfunction

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp_v);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge adc_clk) begin
    logic [EW-1:0] e;
    if (reset) begin
      prev_strobe = 1'b0;
    end else begin
      if (out_strobe) begin
        strobe_cnt++;
        check("strobe_back_to_back", 48'(prev_strobe), 48'(0));
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe at cycle %0d: got i=%0h q=%0h expected no strobe",
                   cyc, out_data_i, out_data_q);
        end else begin
          e = exp_q.pop_front();
          check("out_time", 48'(cyc), 48'(e[EW-1 -: 32]));
          check("out_i", 48'(out_data_i), 48'(e[2*WIDTH-1 -: WIDTH]));
          check("out_q", 48'(out_data_q), 48'(e[WIDTH-1:0]));
        end
      end
      prev_strobe = out_strobe;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge adc_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_strobe = 1'b0;
    coef_wr   = 1'b0;
    exp_q.delete();
    step(3);
    reset = 1'b0;
    model_reset();
    step(1);
  endtask

  task automatic write_coef(input int a, input logic [COEFF-1:0] d);
    coef_wr   = 1'b1;
    coef_addr = AW'(a);
    coef_data = d;
    step(1);
    coef_wr = 1'b0;
    if (a <= NH) tm[a] = int'($signed(d));
  endtask

  task automatic send(input logic [WIDTH-1:0] di, input logic [WIDTH-1:0] dq,
                      input bit want_p1, input int gap);
    int c;
    c = cyc;
    in_strobe = 1'b1;
    in_data_i = di;
    in_data_q = dq;
    hist_i.push_back(int'($signed(di)));
    hist_q.push_back(int'($signed(dq)));
    exp_q.push_back({32'(c + LAT_P0), model_y(0, 1'b0), model_y(0, 1'b1)});
    if (want_p1) exp_q.push_back({32'(c + LAT_P1), model_y(1, 1'b0), model_y(1, 1'b1)});
    step(1);
    in_strobe = 1'b0;
    step(gap - 1);
  endtask

  // A strobe the DUT must drop: it never enters the model.
  task automatic stray(input logic [WIDTH-1:0] di, input logic [WIDTH-1:0] dq);
    in_strobe = 1'b1;
    in_data_i = di;
    in_data_q = dq;
    step(1);
    in_strobe = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step(1);
      n++;
    end
    check("drain_pending", 48'(exp_q.size()), 48'(0));
    step(2);
  endtask

  task automatic run_default();
    for (int x = 1; x <= 20; x++) send(WIDTH'(x), WIDTH'(-x), 1'b1, 40);
    wait_drain();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    reset     = 1'b1;
    in_strobe = 1'b0;
    in_data_i = '0;
    in_data_q = '0;
    coef_wr   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    model_reset();
    step(2);

    do_reset();
    check("rst_out_strobe", 48'(out_strobe), 48'(0));
    check("rst_out_i", 48'(out_data_i), 48'(0));
    check("rst_out_q", 48'(out_data_q), 48'(0));
    check("rst_busy", 48'(busy), 48'(0));
    check("rst_overrun", 48'(overrun), 48'(0));

    // Default coefficients: phase 0 is an 8-sample delay, phase 1 is zero.
    run_default();

    // Impulse response: outputs read 1..17..1 then zeros.
    do_reset();
    for (int j = 0; j <= NH; j++) write_coef(j, COEFF'(j + 1));
    send(24'h010000, 24'h010000, 1'b1, 37);
    for (int j = 0; j < 17; j++) send('0, '0, 1'b1, 37);
    wait_drain();

    // Saturation on both rails with opposite signs.
    do_reset();
    write_coef(NH, 18'h1FFFF);
    send(24'h7FFFFF, 24'h800000, 1'b1, 37);
    send(24'h800000, 24'h7FFFFF, 1'b1, 37);
    for (int j = 0; j < 9; j++) send('0, '0, 1'b1, 37);
    wait_drain();

    // Overrun: a strobe 10 cycles in is dropped and flagged.
    do_reset();
    send(WIDTH'($urandom), WIDTH'($urandom), 1'b1, 10);
    check("ovr_busy_mid", 48'(busy), 48'(1));
    check("ovr_flag_before", 48'(overrun), 48'(0));
    stray(WIDTH'($urandom), WIDTH'($urandom));
    check("ovr_flag_set", 48'(overrun), 48'(1));
    step(26);
    send(WIDTH'($urandom), WIDTH'($urandom), 1'b1, 37);
    send(WIDTH'($urandom), WIDTH'($urandom), 1'b1, 37);
    wait_drain();
    check("ovr_flag_sticky", 48'(overrun), 48'(1));

    // Back-to-back random traffic with random coefficients.
    do_reset();
    for (int j = 0; j <= NH; j++) write_coef(j, COEFF'(int'($urandom_range(0, 16383)) - 8192));
    for (int a = NH + 1; a < (1 << AW); a++) write_coef(a, COEFF'($urandom));
    base = strobe_cnt;
    for (int s = 0; s < 100; s++) send(WIDTH'($urandom), WIDTH'($urandom), 1'b1, 37);
    wait_drain();
    check("b2b_strobe_count", 48'(strobe_cnt - base), 48'(200));
    check("b2b_overrun", 48'(overrun), 48'(0));

    // Reset during MAC1: phase 1 never appears, defaults restored.
    send(WIDTH'($urandom), WIDTH'($urandom), 1'b0, 25);
    check("abort_busy", 48'(busy), 48'(1));
    check("abort_p0_seen", 48'(exp_q.size()), 48'(0));
    do_reset();
    check("abort_busy_after", 48'(busy), 48'(0));
    check("abort_strobe_after", 48'(out_strobe), 48'(0));
    run_default();
    check("final_overrun", 48'(overrun), 48'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout at cycle %0d: got no completion expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
